// File: rtl/stream_mux_rr.sv
// N:1 streaming mux with a one-entry registered output, valid/ready handshake,
// and either fixed-select or round-robin channel selection.

module stream_mux_rr_lane #(
  parameter int SEL_W = 3,
  parameter int IDX   = 0
) (
  input  logic             load_en,
  input  logic             grant_hit,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] g,
  output logic             in_ready
);
  assign in_ready = load_en && grant_hit && in_valid && (g == SEL_W'(IDX));
endmodule

module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_ch
);
  logic [CHANNELS-1:0][WIDTH-1:0] ch_data;
  logic [WIDTH-1:0]               out_data_q, out_data_d;
  logic                           out_valid_q, out_valid_d;
  logic [SEL_W-1:0]               out_ch_q, out_ch_d;
  logic [SEL_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]               g;
  logic [SEL_W:0]                 idx;
  logic                           grant_hit, load_en, accept;

  assign ch_data = in_data;
  // Gated with rst_n so no handshake can be offered while reset is held.
  assign load_en = rst_n && (!out_valid_q || out_ready);
  assign accept  = load_en && grant_hit;

  always_comb begin
    grant_hit = 1'b0;
    g         = '0;
    idx       = '0;
    if (!mode) begin
      if ({1'b0, sel} < (SEL_W+1)'(CHANNELS)) begin
        g         = sel;
        grant_hit = in_valid[sel];
      end
    end else begin
      // Scan from rr_ptr with an explicit wrap so non-power-of-2 counts work.
      for (int i = 0; i < CHANNELS; i++) begin
        idx = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
        if (idx >= (SEL_W+1)'(CHANNELS)) idx = idx - (SEL_W+1)'(CHANNELS);
        if (!grant_hit && in_valid[idx[SEL_W-1:0]]) begin
          grant_hit = 1'b1;
          g         = idx[SEL_W-1:0];
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      stream_mux_rr_lane #(.SEL_W(SEL_W), .IDX(k)) u_lane (
        .load_en  (load_en),
        .grant_hit(grant_hit),
        .in_valid (in_valid[k]),
        .g        (g),
        .in_ready (in_ready[k])
      );
    end
  endgenerate

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = grant_hit;
      if (grant_hit) begin
        out_data_d = ch_data[g];
        out_ch_d   = g;
      end
    end
    if (accept && mode)
      rr_ptr_d = (g == SEL_W'(CHANNELS-1)) ? '0 : g + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: an 8-channel instance for the main paths and
// a 5-channel instance for out-of-range sel, odd-count wrap and mid-stream reset.
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0] a_in_data;
  logic [7:0]  a_in_valid, a_in_ready, a_out_data;
  logic        a_mode, a_out_valid, a_out_ready;
  logic [2:0]  a_sel, a_out_ch;

  logic [39:0] b_in_data;
  logic [4:0]  b_in_valid, b_in_ready;
  logic [7:0]  b_out_data;
  logic        b_mode, b_out_valid, b_out_ready;
  logic [2:0]  b_sel, b_out_ch;

  int checks = 0;
  int errors = 0;

  stream_mux_rr #(.WIDTH(8), .CHANNELS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .mode(a_mode), .sel(a_sel), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ch(a_out_ch));

  stream_mux_rr #(.WIDTH(8), .CHANNELS(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ch(b_out_ch));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_data = 64'h0706050403020100; a_in_valid = 8'hFF; a_mode = 1'b0;
    a_sel = 3'd0; a_out_ready = 1'b1;
    b_in_data = 40'h1413121110; b_in_valid = 5'h00; b_mode = 1'b0;
    b_sel = 3'd0; b_out_ready = 1'b1;

    // Reset with every channel valid
    #3;
    chk("rst_valid", a_out_valid, 0);
    chk("rst_data", a_out_data, 0);
    chk("rst_ch", a_out_ch, 0);
    chk("rst_ready", a_in_ready, 0);
    @(posedge clk); #1;
    chk("rst_ready_clk", a_in_ready, 0);
    chk("rst_valid_clk", a_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed mode, sel=3
    a_in_valid = 8'h08; a_sel = 3'd3; a_in_data = 64'h0; a_in_data[31:24] = 8'hA5;
    #1 chk("fix_ready", a_in_ready, 8'h08);
    @(negedge clk);
    chk("fix_data", a_out_data, 8'hA5);
    chk("fix_valid", a_out_valid, 1);
    chk("fix_ch", a_out_ch, 3);

    // Round-robin, all valid: 0..7,0 back to back
    a_in_data = 64'h0706050403020100; a_in_valid = 8'hFF; a_mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1 chk("rr_ready", a_in_ready, 8'h01 << (i % 8));
      @(negedge clk);
      chk("rr_ch", a_out_ch, i % 8);
      chk("rr_data", a_out_data, i % 8);
      chk("rr_valid", a_out_valid, 1);
    end

    // Move rr_ptr to 2 by accepting ch1, then 7 / 1 / 7
    a_in_valid = 8'h02;
    @(negedge clk);
    chk("rr_pre_ch", a_out_ch, 1);
    a_in_valid = 8'h82;
    #1 chk("rr_w7a_ready", a_in_ready, 8'h80);
    @(negedge clk); chk("rr_w7a_ch", a_out_ch, 7);
    #1 chk("rr_w1_ready", a_in_ready, 8'h02);
    @(negedge clk); chk("rr_w1_ch", a_out_ch, 1);
    #1 chk("rr_w7b_ready", a_in_ready, 8'h80);
    @(negedge clk); chk("rr_w7b_ch", a_out_ch, 7);

    // Backpressure for 3 cycles, word 7 held; rr_ptr is 0
    a_in_valid = 8'hFF; a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", a_in_ready, 0);
      @(negedge clk);
      chk("bp_data", a_out_data, 8'h07);
      chk("bp_ch", a_out_ch, 7);
      chk("bp_valid", a_out_valid, 1);
    end
    a_out_ready = 1'b1;
    #1 chk("bp_rel_ready", a_in_ready, 8'h01);
    @(negedge clk);
    chk("bp_rel_ch", a_out_ch, 0);
    chk("bp_rel_valid", a_out_valid, 1);
    a_in_valid = 8'h00;
    @(negedge clk);
    chk("idle_valid", a_out_valid, 0);
    chk("idle_ch_hold", a_out_ch, 0);
    chk("idle_data_hold", a_out_data, 8'h00);

    // 5-channel: load ch2, then out-of-range sel
    b_in_valid = 5'h1F; b_sel = 3'd2;
    #1 chk("b_fix_ready", b_in_ready, 5'h04);
    @(negedge clk);
    chk("b_fix_valid", b_out_valid, 1);
    chk("b_fix_ch", b_out_ch, 2);
    chk("b_fix_data", b_out_data, 8'h12);
    b_sel = 3'd6;
    #1 chk("b_oor_ready", b_in_ready, 0);
    @(negedge clk);
    chk("b_oor_valid", b_out_valid, 0);
    chk("b_oor_data_hold", b_out_data, 8'h12);

    // 5-channel round-robin wrap at 4 -> 0
    b_mode = 1'b1; b_in_valid = 5'h10;
    #1 chk("b_rr4_ready", b_in_ready, 5'h10);
    @(negedge clk);
    chk("b_rr4_ch", b_out_ch, 4);
    chk("b_rr4_data", b_out_data, 8'h14);
    b_in_valid = 5'h1F;
    #1 chk("b_rr0_ready", b_in_ready, 5'h01);
    @(negedge clk);
    chk("b_rr0_ch", b_out_ch, 0);
    chk("b_rr0_valid", b_out_valid, 1);

    // Reset mid-stream drops the held word at once
    rst_n = 1'b0;
    #1;
    chk("b_mrst_valid", b_out_valid, 0);
    chk("b_mrst_ready", b_in_ready, 0);
    chk("b_mrst_ch", b_out_ch, 0);
    @(negedge clk);
    chk("b_mrst_ready_hold", b_in_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: simulation did not reach the end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
